// File: rtl/mfcc_frame_scheduler.sv
// Ring-buffers the audio sample stream and sequences overlapping FRAME_LEN/HOP_LEN frames into the Hamming stage.
// Define MFCC_SCHED_DROP_CNT_EN to add the saturating dropped-sample counter drop_count_o.
module mfcc_frame_scheduler #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 306,
  parameter int HOP_LEN      = 128,
  parameter int BUF_DEPTH    = 1024,
  parameter int BUF_ADDR_W   = $clog2(BUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  input  logic                    fft_ready_i,
  output logic                    hw_start_o,
  input  logic                    hw_rd_en_i,
  output logic [SAMPLE_WIDTH-1:0] hw_sample_o,
  output logic                    hw_valid_o,
  input  logic                    hw_done_i,
  output logic                    busy_o,
  output logic [15:0]             frame_count_o,
  output logic                    overrun_o,
`ifdef MFCC_SCHED_DROP_CNT_EN
  output logic [15:0]             drop_count_o,
`endif
  input  logic                    clear_overrun_i
);

  localparam int RD_W = $clog2(FRAME_LEN + 1);
  localparam logic [BUF_ADDR_W:0]   FILL_FULL  = (BUF_ADDR_W+1)'(BUF_DEPTH);
  localparam logic [BUF_ADDR_W:0]   FILL_FRAME = (BUF_ADDR_W+1)'(FRAME_LEN);
  localparam logic [BUF_ADDR_W:0]   FILL_HOP   = (BUF_ADDR_W+1)'(HOP_LEN);
  localparam logic [BUF_ADDR_W:0]   FILL_ONE   = (BUF_ADDR_W+1)'(1);
  localparam logic [BUF_ADDR_W-1:0] ADDR_HOP   = BUF_ADDR_W'(HOP_LEN);
  localparam logic [BUF_ADDR_W-1:0] ADDR_ONE   = BUF_ADDR_W'(1);
  localparam logic [RD_W-1:0]       RD_LAST    = RD_W'(FRAME_LEN);
  localparam logic [RD_W-1:0]       RD_ONE     = RD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_START, S_STREAM, S_WAIT_DONE, S_ADVANCE
  } state_t;

  state_t                  state_q, state_d;
  logic [BUF_ADDR_W-1:0]   wr_ptr_q, base_q;
  logic [BUF_ADDR_W:0]     fill_q, fill_d;
  logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic                    valid_q;
  logic [15:0]             frame_cnt_q;
  logic                    overrun_q, overrun_d;
  logic [SAMPLE_WIDTH-1:0] rd_data_q;
  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];

  logic                    wr_en, drop, issue, retire;
  logic [BUF_ADDR_W-1:0]   rd_addr;

  assign wr_en   = sample_valid_i && (fill_q != FILL_FULL);
  assign drop    = sample_valid_i && (fill_q == FILL_FULL);
  assign issue   = (state_q == S_STREAM) && hw_rd_en_i && (rd_cnt_q < RD_LAST);
  assign retire  = (state_q == S_ADVANCE);
  assign rd_addr = base_q + BUF_ADDR_W'(rd_cnt_q);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE:      state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (enable_i && fft_ready_i && (fill_q >= FILL_FRAME)) state_d = S_START;
      S_START: begin
        rd_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (issue) rd_cnt_d = rd_cnt_q + RD_ONE;
        // Leave only once the final read's data has been presented.
        if ((rd_cnt_q == RD_LAST) && valid_q) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (hw_done_i) state_d = S_ADVANCE;
      S_ADVANCE:   state_d = S_WAIT_DATA;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    if (wr_en)  fill_d = fill_d + FILL_ONE;
    if (retire) fill_d = fill_d - FILL_HOP;
    overrun_d = overrun_q;
    if (clear_overrun_i) overrun_d = 1'b0;
    if (drop)            overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      fill_q      <= '0;
      rd_cnt_q    <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      rd_cnt_q  <= rd_cnt_d;
      valid_q   <= issue;
      overrun_q <= overrun_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_ONE;
      if (retire) begin
        base_q      <= base_q + ADDR_HOP;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Sample storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_i;
    if (issue) rd_data_q <= mem[rd_addr];
  end

`ifdef MFCC_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (clear_overrun_i) begin
      drop_cnt_q <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign hw_start_o    = (state_q == S_START);
  assign hw_valid_o    = valid_q;
  assign hw_sample_o   = valid_q ? rd_data_q : '0;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_WAIT_DATA);
  assign frame_count_o = frame_cnt_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed bench for mfcc_frame_scheduler: frame sequencing, read latency, overrun, buffer wrap and async reset.
module tb_mfcc_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0, sample_valid_i = 1'b0, fft_ready_i = 1'b0;
  logic        hw_rd_en_i = 1'b0, hw_done_i = 1'b0, clear_overrun_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        hw_start_o, hw_valid_o, busy_o, overrun_o;
  logic [15:0] hw_sample_o, frame_count_o;
`ifdef MFCC_SCHED_DROP_CNT_EN
  logic [15:0] drop_count_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  int no_req_valid = 0;
  int nxt = 0;
  int vdat[$];
  int vcyc[$];
  logic prev_rd = 1'b0;

  mfcc_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .fft_ready_i(fft_ready_i),
    .hw_start_o(hw_start_o), .hw_rd_en_i(hw_rd_en_i), .hw_sample_o(hw_sample_o),
    .hw_valid_o(hw_valid_o), .hw_done_i(hw_done_i), .busy_o(busy_o),
    .frame_count_o(frame_count_o), .overrun_o(overrun_o),
`ifdef MFCC_SCHED_DROP_CNT_EN
    .drop_count_o(drop_count_o),
`endif
    .clear_overrun_i(clear_overrun_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid beat and start pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (hw_valid_o) begin
      vdat.push_back(int'(hw_sample_o));
      vcyc.push_back(cyc);
      if (!prev_rd) no_req_valid++;
    end
    if (hw_start_o) begin
      starts++;
      start_cyc = cyc;
    end
    prev_rd = hw_rd_en_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      sample_i = 16'(nxt);
      sample_valid_i = 1'b1;
      step();
      nxt++;
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_valids(input int n, input int bound);
    int k = 0;
    while (vdat.size() < n && k < bound) begin
      step();
      k++;
    end
  endtask

  task automatic finish_frame();
    step(); step();
    hw_done_i = 1'b1;
    step();
    hw_done_i = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (hw_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", hw_start_o); end
    checks++; if (hw_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", hw_valid_o); end
    checks++; if (hw_sample_o !== 16'd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", hw_sample_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_frame();
    int last_wr, bad;
    vdat.delete(); vcyc.delete(); starts = 0;
    enable_i = 1'b1; fft_ready_i = 1'b1; hw_rd_en_i = 1'b1;
    hw_done_i = 1'b1;
    step();
    hw_done_i = 1'b0;
    step();
    feed(306);
    last_wr = cyc;
    wait_valids(306, 1000);
    checks++; if (starts != 1) begin errors++; $display("FAIL f1_start_count: got %0d expected 1", starts); end
    checks++; if (start_cyc != last_wr + 1) begin errors++; $display("FAIL f1_start_latency: got cycle %0d expected %0d", start_cyc, last_wr + 1); end
    checks++; if (vdat.size() != 306) begin errors++; $display("FAIL f1_beats: got %0d expected 306", vdat.size()); end
    if (vcyc.size() == 306) begin
      checks++; if (vcyc[0] != start_cyc + 2) begin errors++; $display("FAIL f1_first_valid_cycle: got %0d expected %0d", vcyc[0], start_cyc + 2); end
      checks++; if (vcyc[305] != start_cyc + 307) begin errors++; $display("FAIL f1_last_valid_cycle: got %0d expected %0d", vcyc[305], start_cyc + 307); end
    end
    bad = 0;
    for (int i = 0; i < vdat.size(); i++) if (vdat[i] != i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL f1_data: got %0d wrong samples expected 0", bad); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL f1_busy_wait_done: got %b expected 1", busy_o); end
    checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL f1_early_done_ignored: got %0d expected 0", frame_count_o); end
    repeat (5) step();
    checks++; if (vdat.size() != 306) begin errors++; $display("FAIL f1_no_extra_valid: got %0d expected 306", vdat.size()); end
    finish_frame();
    checks++; if (frame_count_o !== 16'd1) begin errors++; $display("FAIL f1_frame_count: got %0d expected 1", frame_count_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL f1_busy_after: got %b expected 0", busy_o); end
  endtask

  task automatic test_second_frame();
    int bad;
    vdat.delete(); vcyc.delete(); starts = 0;
    feed(128);
    wait_valids(306, 1000);
    checks++; if (starts != 1) begin errors++; $display("FAIL f2_start_count: got %0d expected 1", starts); end
    checks++; if (vdat.size() != 306) begin errors++; $display("FAIL f2_beats: got %0d expected 306", vdat.size()); end
    if (vdat.size() == 306) begin
      checks++; if (vdat[0] != 128) begin errors++; $display("FAIL f2_first: got %0d expected 128", vdat[0]); end
      checks++; if (vdat[305] != 433) begin errors++; $display("FAIL f2_last: got %0d expected 433", vdat[305]); end
    end
    bad = 0;
    for (int i = 0; i < vdat.size(); i++) if (vdat[i] != 128 + i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL f2_data: got %0d wrong samples expected 0", bad); end
    finish_frame();
    checks++; if (frame_count_o !== 16'd2) begin errors++; $display("FAIL f2_frame_count: got %0d expected 2", frame_count_o); end
  endtask

  task automatic test_rd_toggle();
    int bad, bad_gap;
    hw_rd_en_i = 1'b0;
    vdat.delete(); vcyc.delete(); starts = 0;
    feed(128);
    no_req_valid = 0;
    for (int i = 0; i < 800; i++) begin
      hw_rd_en_i = i[0];
      step();
    end
    hw_rd_en_i = 1'b0;
    step(); step();
    checks++; if (vdat.size() != 306) begin errors++; $display("FAIL tog_beats: got %0d expected 306", vdat.size()); end
    checks++; if (no_req_valid != 0) begin errors++; $display("FAIL tog_latency: got %0d valids without a request one cycle earlier expected 0", no_req_valid); end
    bad_gap = 0;
    for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 2) bad_gap++;
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL tog_spacing: got %0d irregular gaps expected 0", bad_gap); end
    bad = 0;
    for (int i = 0; i < vdat.size(); i++) if (vdat[i] != 256 + i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL tog_data: got %0d wrong samples expected 0", bad); end
    finish_frame();
    checks++; if (frame_count_o !== 16'd3) begin errors++; $display("FAIL tog_frame_count: got %0d expected 3", frame_count_o); end
  endtask

  task automatic test_wrap();
    int bad;
    hw_rd_en_i = 1'b1;
    for (int f = 3; f <= 7; f++) begin
      vdat.delete(); vcyc.delete();
      feed(128);
      wait_valids(306, 1000);
      checks++; if (vdat.size() != 306) begin errors++; $display("FAIL wrap_beats_f%0d: got %0d expected 306", f, vdat.size()); end
      bad = 0;
      for (int i = 0; i < vdat.size(); i++) if (vdat[i] != f * 128 + i) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data_f%0d: got %0d wrong samples expected 0", f, bad); end
      finish_frame();
    end
    checks++; if (frame_count_o !== 16'd8) begin errors++; $display("FAIL wrap_frame_count: got %0d expected 8", frame_count_o); end
  endtask

  task automatic test_overrun();
    int bad;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    nxt = 0;
    enable_i = 1'b1; fft_ready_i = 1'b0; hw_rd_en_i = 1'b1;
    vdat.delete(); vcyc.delete(); starts = 0;
    feed(1024);
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_full_no_flag: got %b expected 0", overrun_o); end
    feed(1);
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_o); end
    feed(75);
`ifdef MFCC_SCHED_DROP_CNT_EN
    checks++; if (drop_count_o !== 16'd76) begin errors++; $display("FAIL ovr_drop_count: got %0d expected 76", drop_count_o); end
`endif
    clear_overrun_i = 1'b1; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", overrun_o); end
    step();
    clear_overrun_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
`ifdef MFCC_SCHED_DROP_CNT_EN
    checks++; if (drop_count_o !== 16'd0) begin errors++; $display("FAIL ovr_drop_clear: got %0d expected 0", drop_count_o); end
`endif
    checks++; if (starts != 0) begin errors++; $display("FAIL ovr_no_start_when_not_ready: got %0d expected 0", starts); end
    fft_ready_i = 1'b1;
    wait_valids(306, 1000);
    checks++; if (vdat.size() != 306) begin errors++; $display("FAIL ovr_beats: got %0d expected 306", vdat.size()); end
    bad = 0;
    for (int i = 0; i < vdat.size(); i++) if (vdat[i] != i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovr_data: got %0d wrong samples expected 0", bad); end
    finish_frame();
    checks++; if (frame_count_o !== 16'd1) begin errors++; $display("FAIL ovr_frame_count: got %0d expected 1", frame_count_o); end
  endtask

  task automatic test_reset_mid_stream();
    int k;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    nxt = 0;
    enable_i = 1'b1; fft_ready_i = 1'b1; hw_rd_en_i = 1'b0;
    feed(306);
    k = 0;
    while (!hw_start_o && k < 10) begin step(); k++; end
    checks++; if (hw_start_o !== 1'b1) begin errors++; $display("FAIL mid_start_seen: got %b expected 1", hw_start_o); end
    hw_rd_en_i = 1'b1;
    step();
    repeat (100) step();
    hw_rd_en_i = 1'b0;
    checks++; if (hw_valid_o !== 1'b1) begin errors++; $display("FAIL mid_streaming: got %b expected 1", hw_valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (hw_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", hw_valid_o); end
    checks++; if (hw_sample_o !== 16'd0) begin errors++; $display("FAIL mid_rst_sample: got %0d expected 0", hw_sample_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy_o); end
    checks++; if (hw_start_o !== 1'b0) begin errors++; $display("FAIL mid_rst_start: got %b expected 0", hw_start_o); end
    step();
    rst_n = 1'b1;
    step();
    starts = 0;
    feed(305);
    repeat (20) step();
    checks++; if (starts != 0) begin errors++; $display("FAIL mid_no_start_early: got %0d expected 0", starts); end
    feed(1);
    repeat (3) step();
    checks++; if (starts != 1) begin errors++; $display("FAIL mid_start_after_refill: got %0d expected 1", starts); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_rd_toggle();
    test_wrap();
    test_overrun();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
